// File: rtl/and_reduce_serial.sv
// -----------------------------------------------------------------------------
// and_reduce_serial
//
// Purpose:
//   Serial AND-reduction of a WIDTH-bit operand that arrives as a stream of
//   4-bit nibbles, least-significant nibble first. Each operation is opened
//   with start, consumes exactly NIBS nibbles over a valid/ready handshake,
//   and presents a one-bit result that is held until the consumer
//   acknowledges it.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   request a new reduction (IDLE, or DONE together with out_ack)
//   in        in   [3:0] operand nibble
//   in_valid  in   in carries a valid nibble
//   in_ready  out  a nibble is accepted this cycle if in_valid is high
//   out       out  AND of all WIDTH bits of the last completed operand
//   out_valid out  out is valid and held
//   out_ack   in   consumer takes the result
//   count     out  [$clog2(NIBS+1)-1:0] nibbles accepted in current operation
// -----------------------------------------------------------------------------
module and_reduce_serial #(
    parameter int WIDTH = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [3:0]                           in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic                                 out,
    output logic                                 out_valid,
    input  logic                                 out_ack,
    output logic [$clog2((WIDTH/4)+1)-1:0]       count
);

    localparam int NIBS = WIDTH / 4;
    localparam int CW   = $clog2(NIBS + 1);

    // Count value held while the final nibble is being accepted.
    localparam logic [CW-1:0] LAST_IDX = CW'(NIBS - 1);

    // Reject illegal widths at elaboration rather than building a broken
    // counter.
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("and_reduce_serial: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    logic   acc;
    logic   accept;
    logic   nib_and;

    // in_ready depends only on state, so a source can never see it react to
    // its own in_valid within the same cycle.
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    // Only consumed when accept is high, so an X on in while in_valid is low
    // never reaches acc.
    assign nib_and  = &in;

    // NOTE: every register here is assigned with <= so that all updates use
    // values from before the clock edge; a blocking = would let later lines
    // see already-updated state and silently change the behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: acc is a single flop, not a memory, so it is reset along
            // with the rest of the state; a start also reloads it, so a
            // discarded partial operand can never leak into a later result.
            state     <= IDLE;
            acc       <= 1'b1;
            out       <= 1'b0;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_valid is ignored here: nothing is accepted until an
                    // operation has been opened.
                    if (start) begin
                        state <= ACCUM;
                        acc   <= 1'b1;
                        count <= '0;
                    end
                end

                ACCUM: begin
                    // start and out_ack are ignored while accumulating.
                    if (accept) begin
                        acc   <= acc & nib_and;
                        count <= count + 1'b1;
                        // No early exit on a zero nibble: the whole operand
                        // must be drained so the source stays in step.
                        if (count == LAST_IDX) begin
                            state     <= DONE;
                            out       <= acc & nib_and;
                            out_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // out and count are held; start alone does nothing.
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back: straight into the next operation
                            // with no idle bubble.
                            state <= ACCUM;
                            acc   <= 1'b1;
                            count <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/and_reduce_serial.md
Name: and_reduce_serial

Overview:
- Sequential counterpart to the combinational 4-input AND: a WIDTH-bit operand arrives as a stream of 4-bit nibbles and is AND-reduced to one bit.
- Sits between a nibble-wide source and any consumer of a 1-bit reduction result.
- Uses a valid/ready input handshake and a held-result output that the consumer acknowledges.

Parameters:
WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4.
NIBS, WIDTH/4, derived number of nibbles per operation. Not overridable.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new reduction (sampled in IDLE, or in DONE together with out_ack)
in  input  4  operand nibble, least-significant nibble first
in_valid  input  1  in holds a valid nibble
in_ready  output  1  block accepts a nibble this cycle
out  output  1  AND of all WIDTH bits of the completed operand
out_valid  output  1  out is valid and held
out_ack  input  1  consumer takes the result
count  output  $clog2(NIBS+1)  nibbles accepted in the current operation

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on the rising edge of clock. There is no asynchronous reset path.
- Reset values:
  - state = IDLE
  - in_ready = 0, out_valid = 0, out = 0, count = 0
  - internal accumulator acc = 1
- States and transitions:
  - IDLE:
    - start=1 -> ACCUM next cycle, with acc<=1 and count<=0.
    - in_valid is ignored in IDLE.
  - ACCUM:
    - in_ready=1 (combinational from state).
    - A nibble is accepted on a cycle where in_valid & in_ready: acc <= acc & (&in) and count <= count+1.
    - On the cycle the NIBS-th nibble is accepted -> DONE next cycle, with out <= acc & (&in) and out_valid=1.
    - No accept that cycle: state and acc hold.
    - start is ignored in ACCUM.
  - DONE:
    - out_valid=1, in_ready=0, and out and count are held stable.
    - out_ack=1 with start=0 -> IDLE, out_valid<=0.
    - out_ack=1 with start=1 -> ACCUM directly, with acc<=1, count<=0, out_valid<=0. The back-to-back path has zero bubble cycles.
    - start without out_ack is ignored.
    - out_ack outside DONE is ignored.
- Latency: out_valid rises exactly 1 cycle after the accept of the final nibble. Minimum operation is 1 (start) + NIBS (accepts) cycles, then result valid.
- out holds its last value in IDLE and keeps it until the next completion overwrites it. It is only meaningful while out_valid=1.
- No early termination: a zero nibble clears acc, but all NIBS nibbles must still be consumed.
- count saturates at NIBS in DONE and returns to 0 on the next start.
- Reset asserted in any state, including mid-ACCUM or in DONE with a pending result, takes priority over all other inputs. The partial operand is discarded and all outputs take their reset values next cycle.
- in is don't-care when in_valid=0; X on in must not propagate into acc.

Test Plan:
- Reset, then start, then nibbles 4'hF,4'hF,4'hF,4'hF with in_valid held high -> out_valid=1 exactly 1 cycle after the 4th accept, out=1, count=4.
- start; nibbles F,F,7,F -> out=0. Repeat with the zero in the first nibble (0,F,F,F) -> out=0, and all 4 nibbles are still consumed before DONE.
- Gaps: in_valid toggled 1,0,0,1,1,0,1 carrying F nibbles -> only the 4 valid cycles accepted, count advances 1→2→3→4 accordingly, out=1; with in_valid=1 in IDLE beforehand -> count stays 0.
- Hold/ack: out_ack held 0 for 5 cycles in DONE -> out_valid and out stable, in_ready=0. Then out_ack=1 with start=1 -> ACCUM next cycle with count=0, and the next operand (F,F,F,E) gives out=0.
- Reset mid-operation: after 2 F nibbles accepted, reset=1 for 1 cycle -> next cycle state IDLE, in_ready=0, count=0, out_valid=0. A fresh operation of F,F,F,F then gives out=1, proving acc was reinitialised.
